// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte per valid/ready transfer and serialises it
// onto tx_o as start, 8 data bits (LSB first), optional parity and 1 or 2 stop bits.
module uart_tx #(
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       clk_i,
    input  logic       arst_ni,
    input  logic       cfg_parity_en_i,
    input  logic       cfg_parity_type_i,
    input  logic       cfg_stop_bits_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_data_valid_i,
    output logic       tx_data_ready_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_o
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    r_data;
    logic          r_par_en;
    logic          r_par_type;
    logic          r_stop2;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          r_done;
    logic          w_last;
    logic          w_final_stop;
    logic          w_xfer;

    assign w_last       = (r_cnt == CW'(OVERSAMPLE - 1));
    assign w_final_stop = w_last && (((r_state == STOP1) && !r_stop2) || (r_state == STOP2));

    // Accepting in the final stop cycle lets the next start bit follow with no gap.
    assign tx_data_ready_o = (r_state == IDLE) || w_final_stop;
    assign w_xfer          = tx_data_valid_i && tx_data_ready_o;

    assign tx_o      = r_tx;
    assign tx_busy_o = (r_state != IDLE);
    assign tx_done_o = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = 1'b1;

        if (r_state != IDLE) begin
            w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end
            START: begin
                if (w_last) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (w_last) begin
                    if (r_idx == 3'd7) begin
                        w_state_nxt = r_par_en ? PARITY : STOP1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_last) begin
                    w_state_nxt = STOP1;
                end
            end
            STOP1: begin
                if (w_last) begin
                    if (r_stop2) begin
                        w_state_nxt = STOP2;
                    end else begin
                        w_state_nxt = w_xfer ? START : IDLE;
                    end
                end
            end
            STOP2: begin
                if (w_last) begin
                    w_state_nxt = w_xfer ? START : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // The line level is registered alongside the state, so it is derived from the next state.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = r_data[w_idx_nxt];
            PARITY:  w_tx_nxt = (^r_data) ^ r_par_type;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_data     <= 8'h00;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_stop2    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_final_stop;
            if (w_xfer) begin
                r_data     <= tx_data_i;
                r_par_en   <= cfg_parity_en_i;
                r_par_type <= cfg_parity_type_i;
                r_stop2    <= cfg_stop_bits_i;
            end
        end
    end

endmodule
